// File: rtl/jtl_delay_pkg.sv
// Shared types and constants for the JTL delay line: channel state encoding
// and the saturating drop-counter definition.
package jtl_delay_pkg;

   typedef enum logic [1:0] {
      CH_IDLE   = 2'd0,
      CH_ACTIVE = 2'd1,
      CH_PEND   = 2'd2
   } chan_state_t;

   localparam int DROP_W = 8;
   localparam logic [DROP_W-1:0] DROP_SAT = '1;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == DROP_SAT) ? v : v + DROP_W'(1);
   endfunction

endpackage

// File: rtl/jtl_delay_chan.sv
// One SFQ delay channel: separation gate, programmable-tap shift line,
// deferred-config FSM, sticky violation flag and saturating reject counter.
module jtl_delay_chan
   import jtl_delay_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int MIN_SEP       = 2,
   parameter int DEFAULT_DELAY = 3,
   parameter int DW            = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              bias_ok,
   input  logic              cfg_we,
   input  logic [DW-1:0]     cfg_delay,
   input  logic              viol_clr,
   output logic              pulse_out,
   output logic              viol,
   output logic              busy,
   output logic              cfg_pend,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int SW = $clog2(MIN_SEP + 1);
   localparam logic [SW-1:0] GAP_OPEN = SW'(MIN_SEP);

   chan_state_t      state, state_next;
   logic [DEPTH-1:0] line, line_shift, line_next, live_mask;
   logic [DW-1:0]    cur_delay, pend_delay, load_val;
   logic [SW-1:0]    gap;
   logic             window_open, accept, sep_rej, reject;
   logic             load_delay, latch_pend;

   always_comb begin
      window_open = (gap >= GAP_OPEN);
      accept      = pulse_in && bias_ok && window_open;
      sep_rej     = pulse_in && bias_ok && !window_open;
      reject      = pulse_in && !accept;
   end

   // The slot at cur_delay is emitted on this edge, so only slots below it stay in flight.
   always_comb begin
      line_shift = {line[DEPTH-2:0], accept};
      for (int i = 0; i < DEPTH; i++) begin
         live_mask[i] = (i < int'(cur_delay));
      end
      line_next = line_shift & live_mask;
   end

   assign busy = |line;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line      <= '0;
         pulse_out <= 1'b0;
         gap       <= GAP_OPEN;
      end else begin
         line      <= line_next;
         pulse_out <= line_shift[cur_delay];
         if (accept) begin
            gap <= SW'(1);
         end else if (gap < GAP_OPEN) begin
            gap <= gap + SW'(1);
         end
      end
   end

   // A fresh violation takes priority over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         viol     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (sep_rej) begin
            viol <= 1'b1;
         end else if (viol_clr) begin
            viol <= 1'b0;
         end
         if (reject) begin
            drop_cnt <= sat_inc(drop_cnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CH_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A write arriving with pulses in flight, or alongside a new pulse, is parked until the line drains.
   always_comb begin
      state_next = state;
      load_delay = 1'b0;
      load_val   = cfg_delay;
      latch_pend = 1'b0;
      unique case (state)
         CH_IDLE, CH_ACTIVE: begin
            if (cfg_we && (busy || accept)) begin
               latch_pend = 1'b1;
               state_next = CH_PEND;
            end else begin
               load_delay = cfg_we;
               state_next = (|line_next) ? CH_ACTIVE : CH_IDLE;
            end
         end
         CH_PEND: begin
            latch_pend = cfg_we;
            if (!busy && !accept) begin
               load_delay = 1'b1;
               load_val   = cfg_we ? cfg_delay : pend_delay;
               state_next = CH_IDLE;
            end
         end
         default: state_next = CH_IDLE;
      endcase
   end

   always_comb begin
      cfg_pend = (state == CH_PEND);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_delay  <= DW'(DEFAULT_DELAY);
         pend_delay <= '0;
      end else begin
         if (load_delay) begin
            cur_delay <= load_val;
         end
         if (latch_pend) begin
            pend_delay <= cfg_delay;
         end
      end
   end

endmodule

// File: rtl/jtl_delay_line.sv
// Multi-channel SFQ delay line: one jtl_delay_chan per channel plus the
// configuration write decoder.
module jtl_delay_line
   import jtl_delay_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int DEPTH         = 16,
   parameter int MIN_SEP       = 2,
   parameter int DEFAULT_DELAY = 3,
   parameter int DW            = $clog2(DEPTH),
   localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CHANNELS-1:0]        pulse_in,
   input  logic                       bias_ok,
   input  logic                       cfg_we,
   input  logic [CW-1:0]              cfg_ch,
   input  logic [DW-1:0]              cfg_delay,
   input  logic [CHANNELS-1:0]        viol_clr,
   output logic [CHANNELS-1:0]        pulse_out,
   output logic [CHANNELS-1:0]        viol,
   output logic [CHANNELS-1:0]        busy,
   output logic [CHANNELS-1:0]        cfg_pend,
   output logic [DROP_W*CHANNELS-1:0] drop_cnt
);

   // Out-of-range channel numbers match no channel, so such writes vanish.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic we_c;
      assign we_c = cfg_we && (cfg_ch == CW'(c));

      jtl_delay_chan #(
         .DEPTH         (DEPTH),
         .MIN_SEP       (MIN_SEP),
         .DEFAULT_DELAY (DEFAULT_DELAY),
         .DW            (DW)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .pulse_in  (pulse_in[c]),
         .bias_ok   (bias_ok),
         .cfg_we    (we_c),
         .cfg_delay (cfg_delay),
         .viol_clr  (viol_clr[c]),
         .pulse_out (pulse_out[c]),
         .viol      (viol[c]),
         .busy      (busy[c]),
         .cfg_pend  (cfg_pend[c]),
         .drop_cnt  (drop_cnt[c*DROP_W +: DROP_W])
      );
   end

endmodule

// File: tb/tb_jtl_delay_line.sv
// Self-checking bench for jtl_delay_line: directed scenarios followed by random
// traffic, all compared each cycle against a pulse-schedule reference model.
module tb_jtl_delay_line;

   localparam int CH      = 4;
   localparam int DEPTH   = 16;
   localparam int MIN_SEP = 2;
   localparam int DEF     = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bias_ok = 1'b1;
   logic        cfg_we = 1'b0;
   logic [3:0]  pulse_in = '0;
   logic [3:0]  viol_clr = '0;
   logic [1:0]  cfg_ch = '0;
   logic [3:0]  cfg_delay = '0;
   logic [3:0]  pulse_out, viol, busy, cfg_pend;
   logic [31:0] drop_cnt;

   logic        s_cfg_we = 1'b0;
   logic [2:0]  s_pulse = '0;
   logic [2:0]  s_viol_clr = '0;
   logic [1:0]  s_cfg_ch = '0;
   logic [3:0]  s_cfg_delay = '0;
   logic [2:0]  s_pulse_out, s_viol, s_busy, s_cfg_pend;
   logic [23:0] s_drop;

   int errors = 0;
   int checks = 0;

   int   dueq[CH][$];
   int   last_acc[CH];
   int   cur_d[CH];
   int   pcode[CH];
   bit   pend_m[CH];
   bit   viol_m[CH];
   int   drop_m[CH];
   int   mcyc = 0;
   logic [3:0]  e_pout = '0, e_viol = '0, e_busy = '0, e_pend = '0;
   logic [31:0] e_drop = '0;

   logic [3:0] rp, rclr;
   int         lat;

   always #5 clk = ~clk;

   jtl_delay_line #(.CHANNELS(CH), .DEPTH(DEPTH), .MIN_SEP(MIN_SEP), .DEFAULT_DELAY(DEF)) u_dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .bias_ok(bias_ok),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .viol_clr(viol_clr),
      .pulse_out(pulse_out), .viol(viol), .busy(busy), .cfg_pend(cfg_pend), .drop_cnt(drop_cnt)
   );

   // Three-channel copy so that an out-of-range cfg_ch value is representable.
   jtl_delay_line #(.CHANNELS(3), .DEPTH(DEPTH), .MIN_SEP(MIN_SEP), .DEFAULT_DELAY(DEF)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .pulse_in(s_pulse), .bias_ok(bias_ok),
      .cfg_we(s_cfg_we), .cfg_ch(s_cfg_ch), .cfg_delay(s_cfg_delay), .viol_clr(s_viol_clr),
      .pulse_out(s_pulse_out), .viol(s_viol), .busy(s_busy), .cfg_pend(s_cfg_pend), .drop_cnt(s_drop)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s (model cycle %0d): got %0h expected %0h", tag, mcyc, got, exp);
      end
   endtask

   // Reference model: each accepted pulse is scheduled for cycle accept+delay+1.
   task automatic modelStep();
      for (int c = 0; c < CH; c++) begin
         if (!rst_n) begin
            dueq[c].delete();
            last_acc[c] = -1000;
            cur_d[c]    = DEF;
            pcode[c]    = 0;
            pend_m[c]   = 1'b0;
            viol_m[c]   = 1'b0;
            drop_m[c]   = 0;
            e_pout[c]   = 1'b0;
         end else begin
            bit p, we, acc, in_flight;
            p         = pulse_in[c];
            we        = cfg_we && (int'(cfg_ch) == c);
            in_flight = (dueq[c].size() != 0);
            acc       = p && bias_ok && ((mcyc - last_acc[c]) >= MIN_SEP);
            if (acc) begin
               dueq[c].push_back(mcyc + cur_d[c] + 1);
               last_acc[c] = mcyc;
            end
            if (p && bias_ok && !acc) viol_m[c] = 1'b1;
            else if (viol_clr[c]) viol_m[c] = 1'b0;
            if (p && !acc && drop_m[c] < 255) drop_m[c]++;
            if (!pend_m[c]) begin
               if (we) begin
                  if (in_flight || acc) begin
                     pend_m[c] = 1'b1;
                     pcode[c]  = int'(cfg_delay);
                  end else begin
                     cur_d[c] = int'(cfg_delay);
                  end
               end
            end else begin
               if (we) pcode[c] = int'(cfg_delay);
               if (!in_flight && !acc) begin
                  cur_d[c]  = pcode[c];
                  pend_m[c] = 1'b0;
               end
            end
            e_pout[c] = 1'b0;
            if (dueq[c].size() != 0 && dueq[c][0] == mcyc + 1) begin
               e_pout[c] = 1'b1;
               void'(dueq[c].pop_front());
            end
         end
         e_viol[c]          = viol_m[c];
         e_busy[c]          = (dueq[c].size() != 0);
         e_pend[c]          = pend_m[c];
         e_drop[c*8 +: 8]   = 8'(drop_m[c]);
      end
      mcyc++;
   endtask

   task automatic applyStimulus(input logic [3:0] p, input logic we, input logic [1:0] ch,
                                input logic [3:0] d, input logic [3:0] clr);
      pulse_in  = p;
      cfg_we    = we;
      cfg_ch    = ch;
      cfg_delay = d;
      viol_clr  = clr;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("pulse_out", 32'(pulse_out), 32'(e_pout));
      checkOutput("viol", 32'(viol), 32'(e_viol));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("cfg_pend", 32'(cfg_pend), 32'(e_pend));
      checkOutput("drop_cnt", drop_cnt, e_drop);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus('0, 1'b0, 2'd0, 4'd0, '0);
   endtask

   task automatic idleUntil(input int cyc);
      while (mcyc < cyc) idle(1);
   endtask

   initial begin
      rst_n = 1'b0;
      idle(2);
      checkOutput("rst_pulse_out", 32'(pulse_out), 32'd0);
      checkOutput("rst_cfg_pend", 32'(cfg_pend), 32'd0);
      checkOutput("rst_drop", drop_cnt, 32'd0);
      checkOutput("rst3_outputs", {8'd0, s_pulse_out, s_viol, s_busy, s_cfg_pend, 12'd0}, 32'd0);
      checkOutput("rst3_drop", 32'(s_drop), 32'd0);
      rst_n = 1'b1;

      idleUntil(10);
      applyStimulus(4'b0001, 1'b0, 2'd0, 4'd0, '0);
      idleUntil(20);
      applyStimulus(4'b0010, 1'b0, 2'd0, 4'd0, '0);
      applyStimulus(4'b0010, 1'b0, 2'd0, 4'd0, '0);
      idle(1);
      applyStimulus(4'b0010, 1'b0, 2'd0, 4'd0, '0);
      idleUntil(30);
      checkOutput("viol1_set", 32'(viol[1]), 32'd1);
      checkOutput("drop1_one", 32'(drop_cnt[15:8]), 32'd1);
      applyStimulus('0, 1'b0, 2'd0, 4'd0, 4'b0010);
      checkOutput("viol1_cleared", 32'(viol[1]), 32'd0);

      idleUntil(40);
      applyStimulus(4'b1000, 1'b0, 2'd0, 4'd0, '0);
      applyStimulus('0, 1'b1, 2'd3, 4'd7, '0);
      checkOutput("pend3_raised", 32'(cfg_pend[3]), 32'd1);
      idleUntil(50);
      applyStimulus(4'b1000, 1'b0, 2'd0, 4'd0, '0);
      idleUntil(62);

      bias_ok = 1'b0;
      repeat (300) begin
         applyStimulus(4'b0100, 1'b0, 2'd0, 4'd0, '0);
         idle(2);
      end
      checkOutput("drop2_saturated", 32'(drop_cnt[23:16]), 32'd255);
      checkOutput("viol2_quiet", 32'(viol[2]), 32'd0);
      bias_ok = 1'b1;

      applyStimulus('0, 1'b1, 2'd0, 4'd15, '0);
      applyStimulus(4'b0001, 1'b0, 2'd0, 4'd0, '0);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         idle(1);
         if (pulse_out[0] && lat < 0) lat = k + 1;
      end
      checkOutput("ch0_max_latency", 32'(lat), 32'(DEPTH));

      s_cfg_we = 1'b1; s_cfg_ch = 2'd3; s_cfg_delay = 4'd0;
      idle(1);
      s_cfg_we = 1'b0; s_pulse = 3'b111;
      idle(1);
      s_pulse = '0;
      checkOutput("oob_early_a", 32'(s_pulse_out), 32'd0);
      idle(1);
      checkOutput("oob_early_b", 32'(s_pulse_out), 32'd0);
      idle(1);
      checkOutput("oob_early_c", 32'(s_pulse_out), 32'd0);
      idle(1);
      checkOutput("oob_latency", 32'(s_pulse_out), 32'b111);
      checkOutput("oob_pend", 32'(s_cfg_pend), 32'd0);

      applyStimulus(4'b1111, 1'b0, 2'd0, 4'd0, '0);
      applyStimulus('0, 1'b1, 2'd1, 4'd9, '0);
      rst_n = 1'b0;
      idle(1);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_drop", drop_cnt, 32'd0);
      checkOutput("midrst_pend", 32'(cfg_pend), 32'd0);
      rst_n = 1'b1;
      idle(20);

      repeat (4000) begin
         rst_n   = ($urandom_range(0, 999) != 0);
         bias_ok = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < CH; i++) begin
            rp[i]   = ($urandom_range(0, 9) < 3);
            rclr[i] = ($urandom_range(0, 19) == 0);
         end
         applyStimulus(rp, ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), rclr);
      end
      rst_n   = 1'b1;
      bias_ok = 1'b1;
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
